// File: rtl/exu_div.sv
// Iterative radix-2 restoring unsigned divide/remainder unit for the EXU.
// Optional build macro: DIV_EARLY_OUT_EN (skip iteration when divisor is 0 or dividend < divisor).

package exu_div_pkg;
  localparam int XLEN                = 32;
  localparam int REG_FILE_ADDR_WIDTH = 5;
  localparam int INSTR_TAG_WIDTH     = 4;

  typedef struct packed {
    logic                           legal;
    logic                           nop;
    logic                           divu;
    logic                           remu;
    logic [XLEN-1:0]                rs1_data;
    logic [XLEN-1:0]                rs2_data;
    logic [REG_FILE_ADDR_WIDTH-1:0] rd_addr;
    logic [INSTR_TAG_WIDTH-1:0]     instr_tag;
  } idu1_out_t;
endpackage

module exu_div #(
  parameter int XLEN                = exu_div_pkg::XLEN,
  parameter int REG_FILE_ADDR_WIDTH = exu_div_pkg::REG_FILE_ADDR_WIDTH
) (
  input  logic                                    clk,
  input  logic                                    rstn,
  input  exu_div_pkg::idu1_out_t                  idu1_out,
  input  logic                                    pipe_flush,
  output logic                                    exu_div_busy,
  output logic [XLEN-1:0]                         div_wb_data,
  output logic [REG_FILE_ADDR_WIDTH-1:0]          div_wb_rd_addr,
  output logic                                    div_wb_rd_wr_en,
  output logic [exu_div_pkg::INSTR_TAG_WIDTH-1:0] div_wb_instr_tag
);

  localparam int CNT_W = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, ITER, DONE} state_t;

  state_t                                  state;
  logic [XLEN-1:0]                         q;
  logic [XLEN-1:0]                         rem;
  logic [XLEN-1:0]                         divisor;
  logic [XLEN-1:0]                         dividend;
  logic                                    div_zero;
  logic                                    rem_sel;
  logic [CNT_W-1:0]                        cnt;
  logic [REG_FILE_ADDR_WIDTH-1:0]          rd_addr_q;
  logic [exu_div_pkg::INSTR_TAG_WIDTH-1:0] tag_q;

  logic            accept;
  logic            early_out;
  logic [XLEN:0]   r_shift;
  logic [XLEN:0]   t_sub;
  logic [XLEN-1:0] rem_nxt;
  logic [XLEN-1:0] q_nxt;
  logic [XLEN-1:0] result;

  assign accept = (state != ITER) & idu1_out.legal & ~idu1_out.nop
                & (idu1_out.divu | idu1_out.remu) & ~pipe_flush;

`ifdef DIV_EARLY_OUT_EN
  assign early_out = (idu1_out.rs2_data == '0) || (idu1_out.rs1_data < idu1_out.rs2_data);
`else
  assign early_out = 1'b0;
`endif

  // The restored remainder is always below the divisor, so its carry bit is
  // never stored; only the trial subtraction needs the extra bit.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    rem_nxt = '0;
    q_nxt   = '0;
    result  = '0;
    r_shift = {rem, q[XLEN-1]};
    t_sub   = r_shift - {1'b0, divisor};
    if (!t_sub[XLEN]) begin
      rem_nxt = t_sub[XLEN-1:0];
      q_nxt   = {q[XLEN-2:0], 1'b1};
    end else begin
      rem_nxt = r_shift[XLEN-1:0];
      q_nxt   = {q[XLEN-2:0], 1'b0};
    end
    if (div_zero) result = rem_sel ? dividend : '0;
    else          result = rem_sel ? rem_nxt : q_nxt;
  end

  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: datapath registers are reset as well, so nothing is X after reset.
    if (!rstn) begin
      state            <= IDLE;
      q                <= '0;
      rem              <= '0;
      divisor          <= '0;
      dividend         <= '0;
      div_zero         <= 1'b0;
      rem_sel          <= 1'b0;
      cnt              <= '0;
      rd_addr_q        <= '0;
      tag_q            <= '0;
      exu_div_busy     <= 1'b0;
      div_wb_data      <= '0;
      div_wb_rd_addr   <= '0;
      div_wb_rd_wr_en  <= 1'b0;
      div_wb_instr_tag <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples the pre-edge values of the others.
      exu_div_busy     <= 1'b0;
      div_wb_data      <= '0;
      div_wb_rd_addr   <= '0;
      div_wb_rd_wr_en  <= 1'b0;
      div_wb_instr_tag <= '0;
      case (state)
        IDLE, DONE: begin
          // DONE shares the accept path so a back-to-back divide loses no cycle.
          if (accept) begin
            q         <= idu1_out.rs1_data;
            dividend  <= idu1_out.rs1_data;
            divisor   <= idu1_out.rs2_data;
            div_zero  <= (idu1_out.rs2_data == '0);
            rem_sel   <= idu1_out.remu;
            rd_addr_q <= idu1_out.rd_addr;
            tag_q     <= idu1_out.instr_tag;
            rem       <= '0;
            cnt       <= CNT_W'(XLEN - 1);
            if (early_out) begin
              state            <= DONE;
              div_wb_rd_wr_en  <= 1'b1;
              div_wb_data      <= idu1_out.remu ? idu1_out.rs1_data : '0;
              div_wb_rd_addr   <= idu1_out.rd_addr;
              div_wb_instr_tag <= idu1_out.instr_tag;
            end else begin
              state        <= ITER;
              exu_div_busy <= 1'b1;
            end
          end else begin
            state <= IDLE;
          end
        end
        ITER: begin
          if (pipe_flush) begin
            state <= IDLE;
          end else begin
            rem <= rem_nxt;
            q   <= q_nxt;
            cnt <= cnt - CNT_W'(1);
            if (cnt == '0) begin
              state            <= DONE;
              div_wb_rd_wr_en  <= 1'b1;
              div_wb_data      <= result;
              div_wb_rd_addr   <= rd_addr_q;
              div_wb_instr_tag <= tag_q;
            end else begin
              exu_div_busy <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
